// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_ctrl_pkg: shared state enum and default sizes for the register-file write-port controller
package regfile_ctrl_pkg;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  localparam int XLEN = 32;
  localparam int AW = 5;
  localparam int NREGS = 2 ** AW;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_if: writeback request bus plus the register-file write port
//   req_valid/req_addr/req_data/req_ready : per-requester valid/ready handshake, packed per requester
//   we3/wa3/wd3 : registered write port into the register file
//   init_busy   : high while the post-reset zeroing sweep runs
interface regfile_wb_if #(
  parameter int NREQ = 3,
  parameter int XLEN = regfile_ctrl_pkg::XLEN,
  parameter int AW = regfile_ctrl_pkg::AW
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic we3;
  logic [AW-1:0] wa3;
  logic [XLEN-1:0] wd3;
  logic init_busy;
  modport master (output req_valid, req_addr, req_data, input req_ready, we3, wa3, wd3, init_busy);
  modport slave (input req_valid, req_addr, req_data, output req_ready, we3, wa3, wd3, init_busy);
endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant; search starts at rr_ptr, pointer moves past the winner on adv
//   clk, rst_n : clock, async active-low reset
//   req        : request vector
//   adv        : accept strobe, advances the pointer to winner+1
//   gnt        : one-hot grant, zero when nothing requests
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [N-1:0] req,
  input  logic adv,
  output logic [N-1:0] gnt
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] rr_ptr, win;
  logic found;
  int idx;
  always_comb begin
    gnt = '0;
    win = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr_ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        win = PW'(idx);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= '0;
    else if (adv) rr_ptr <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port among NREQ writeback requesters
//   clk, rst_n : clock, async active-low reset
//   bus        : regfile_wb_if.slave (requests in, req_ready/we3/wa3/wd3/init_busy out)
//   REGFILE_WB_INIT_EN : when defined, reset runs a sweep writing zero to registers 1..2**AW-1
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = regfile_ctrl_pkg::XLEN,
  parameter int AW = regfile_ctrl_pkg::AW
) (
  input logic clk,
  input logic rst_n,
  regfile_wb_if.slave bus
);
  import regfile_ctrl_pkg::*;
  state_t state;
  logic busy, acc;
  logic [NREQ-1:0] gnt;
  logic [AW-1:0] cnt, sel_addr;
  logic [XLEN-1:0] sel_data;
`ifdef REGFILE_WB_INIT_EN
  state_t state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_INIT;
      cnt <= AW'(1);
    end else begin
      state <= state_nxt;
      cnt <= busy ? cnt + AW'(1) : cnt;
    end
  // leave the sweep on the edge that registers the write to the top entry
  always_comb state_nxt = (busy && &cnt) ? ST_RUN : state;
`else
  assign state = ST_RUN;
  assign cnt = AW'(1);
`endif
  assign busy = state == ST_INIT;
  assign acc = !busy && |bus.req_valid;
  rr_arbiter #(.N(NREQ)) u_arb (.clk(clk), .rst_n(rst_n), .req(bus.req_valid), .adv(acc), .gnt(gnt));
  assign bus.req_ready = busy ? '0 : gnt;
  assign bus.init_busy = busy;
  // gnt is one-hot, so an OR of masked lanes selects the winner
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr = sel_addr | (gnt[i] ? bus.req_addr[i*AW +: AW] : '0);
      sel_data = sel_data | (gnt[i] ? bus.req_data[i*XLEN +: XLEN] : '0);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.we3 <= 1'b0;
      bus.wa3 <= '0;
      bus.wd3 <= '0;
    end else if (busy) begin
      bus.we3 <= 1'b1;
      bus.wa3 <= cnt;
      bus.wd3 <= '0;
    end else if (acc) begin
      bus.we3 <= |sel_addr;
      bus.wa3 <= sel_addr;
      bus.wd3 <= sel_data;
    end else bus.we3 <= 1'b0;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized and directed checks of the write-port arbiter against a reference model
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int fails = 0;
  regfile_wb_if #(.NREQ(3), .XLEN(32), .AW(5)) bus ();
  regfile_wb_arbiter #(.NREQ(3), .XLEN(32), .AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [2:0] vld;
  logic [4:0] ta [3];
  logic [31:0] td [3];
  int ptr = 0;
  int last_w;
  logic exp_we;
  logic [4:0] exp_wa;
  logic [31:0] exp_wd;
  logic [31:0] ef [32];
  logic [31:0] rf [32];
  initial for (int r = 0; r < 32; r++) begin
    ef[r] = '0;
    rf[r] = '0;
  end
  always @(posedge clk) if (bus.we3) rf[bus.wa3] <= bus.wd3;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    int w;
    bus.req_valid = vld;
    for (int i = 0; i < 3; i++) begin
      bus.req_addr[i*5 +: 5] = ta[i];
      bus.req_data[i*32 +: 32] = td[i];
    end
    #1;
    w = -1;
    for (int k = 0; k < 3; k++) if (w < 0 && vld[(ptr + k) % 3]) w = (ptr + k) % 3;
    check("ready", 32'(bus.req_ready), w < 0 ? 32'd0 : 32'd1 << w);
    @(posedge clk);
    if (w >= 0) begin
      exp_we = ta[w] != 5'd0;
      exp_wa = ta[w];
      exp_wd = td[w];
      ptr = (w + 1) % 3;
      if (ta[w] != 5'd0) ef[ta[w]] = td[w];
    end else exp_we = 1'b0;
    last_w = w;
    @(negedge clk);
    check("we3", 32'(bus.we3), 32'(exp_we));
    check("wa3", 32'(bus.wa3), 32'(exp_wa));
    check("wd3", bus.wd3, exp_wd);
  endtask
  task automatic reset_dut();
    vld = '0;
    step();
    rst_n = 1'b0;
    #1;
    check("rst_we3", 32'(bus.we3), 0);
    check("rst_wa3", 32'(bus.wa3), 0);
    check("rst_wd3", bus.wd3, 0);
    check("rst_ready", 32'(bus.req_ready), 0);
`ifdef REGFILE_WB_INIT_EN
    check("rst_busy", 32'(bus.init_busy), 1);
`else
    check("rst_busy", 32'(bus.init_busy), 0);
`endif
    ptr = 0;
    exp_wa = '0;
    exp_wd = '0;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef REGFILE_WB_INIT_EN
    repeat (31) @(negedge clk);
    exp_wa = 5'd31;
    for (int r = 1; r < 32; r++) ef[r] = '0;
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    vld = '0;
    for (int i = 0; i < 3; i++) begin
      ta[i] = 5'(i + 1);
      td[i] = '0;
    end
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    exp_we = 1'b0;
    exp_wa = '0;
    exp_wd = '0;
`ifdef REGFILE_WB_INIT_EN
    bus.req_valid = 3'b111;
    bus.req_addr = {5'd3, 5'd2, 5'd1};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      #1;
      check("sw_busy", 32'(bus.init_busy), 1);
      check("sw_ready", 32'(bus.req_ready), 0);
      @(negedge clk);
      check("sw_we3", 32'(bus.we3), 1);
      check("sw_wa3", 32'(bus.wa3), i);
      check("sw_wd3", bus.wd3, 0);
    end
    #1;
    check("sw_done", 32'(bus.init_busy), 0);
    exp_wa = 5'd31;
    vld = 3'b111;
    step();
    check("sw_first", last_w, 0);
    vld = '0;
    step();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("ms_wa3", 32'(bus.wa3), 10);
    rst_n = 1'b0;
    #1;
    check("ms_we3", 32'(bus.we3), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ms_we3b", 32'(bus.we3), 1);
    check("ms_wa3b", 32'(bus.wa3), 1);
    repeat (30) @(negedge clk);
    ptr = 0;
    exp_wa = 5'd31;
    exp_wd = '0;
`else
    @(negedge clk);
    rst_n = 1'b1;
`endif
    reset_dut();
    vld = 3'b111;
    for (int i = 0; i < 3; i++) begin
      ta[i] = 5'(i + 1);
      td[i] = 32'h100 + 32'(i);
    end
    for (int j = 0; j < 6; j++) begin
      step();
      check("rr_order", last_w, j % 3);
    end
    vld = 3'b010;
    ta[1] = 5'd0;
    td[1] = 32'hDEADBEEF;
    step();
    check("x0_gnt", last_w, 1);
    vld = '0;
    step();
    step();
    check("x0_file", rf[0], 0);
    reset_dut();
    vld = 3'b101;
    ta[0] = 5'd5;
    td[0] = 32'h11;
    ta[2] = 5'd5;
    td[2] = 32'h22;
    step();
    vld[last_w] = 1'b0;
    step();
    vld = '0;
    step();
    check("x5_last", rf[5], 32'h22);
    reset_dut();
    vld = 3'b011;
    ta[0] = 5'd7;
    td[0] = 32'hA;
    ta[1] = 5'd8;
    td[1] = 32'hB;
    step();
    check("wd_first", last_w, 0);
    vld = 3'b100;
    ta[2] = 5'd9;
    td[2] = 32'hC;
    step();
    check("wd_req2", last_w, 2);
    vld = 3'b011;
    td[0] = 32'hD;
    step();
    check("wd_ptr", last_w, 0);
    vld = '0;
    step();
    step();
    check("wd_nowr", rf[8], ef[8]);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++)
        if (!vld[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            vld[i] = 1'b1;
            ta[i] = 5'($urandom);
            td[i] = $urandom;
          end
        end else if ($urandom_range(0, 9) == 0) vld[i] = 1'b0;
      step();
      if (last_w >= 0) vld[last_w] = 1'b0;
    end
    vld = '0;
    step();
    step();
    for (int r = 0; r < 32; r++) check("file", rf[r], r == 0 ? 32'd0 : ef[r]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
